// File: rtl/apb_regfile_pkg.sv
// Shared types and decode helpers for the APB slave register file.
package apb_regfile_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE,
    ERR_UNALIGNED,
    ERR_RANGE,
    ERR_RO
  } err_e;

  // Index width leaves room for at least one out-of-range code above the last register.
  function automatic int idx_width(input int num_regs);
    return $clog2(num_regs + 1);
  endfunction

  function automatic int addr_lsb(input int data_width);
    return $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/apb_byte_reg.sv
// One register word with per-byte write enables and a parameterised reset value.
module apb_byte_reg #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    we,
  input  logic [DATA_WIDTH/8-1:0] strb,
  input  logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH-1:0]   q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= RESET_VAL;
    end else begin
      for (int k = 0; k < DATA_WIDTH / 8; k++) begin
        if (we && strb[k]) q[k*8 +: 8] <= wdata[k*8 +: 8];
      end
    end
  end

endmodule

// File: rtl/apb_slave_regfile.sv
// Parametrised APB slave register file with wait states, byte strobes,
// read-only registers and PSLVERR on unaligned/out-of-range/read-only accesses.
module apb_slave_regfile
  import apb_regfile_pkg::*;
#(
  parameter int                             ADDR_WIDTH  = 32,
  parameter int                             DATA_WIDTH  = 32,
  parameter int                             NUM_REGS    = 16,
  parameter int                             WAIT_STATES = 0,
  parameter logic [NUM_REGS-1:0]            RO_MASK     = '0,
  parameter logic [NUM_REGS*DATA_WIDTH-1:0] RESET_VAL   = '0
) (
  input  logic                           PCLK,
  input  logic                           PRESETn,
  input  logic                           PSEL,
  input  logic                           PENABLE,
  input  logic                           PWRITE,
  input  logic [ADDR_WIDTH-1:0]          PADDR,
  input  logic [DATA_WIDTH-1:0]          PWDATA,
  input  logic [DATA_WIDTH/8-1:0]        PSTRB,
  output logic [DATA_WIDTH-1:0]          PRDATA,
  output logic                           PREADY,
  output logic                           PSLVERR,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
  output logic [NUM_REGS-1:0]            wr_pulse
);

  localparam int ADDR_LSB = addr_lsb(DATA_WIDTH);
  localparam int IDX_W    = idx_width(NUM_REGS);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'((64'd1 << ADDR_LSB) - 64'd1);

  state_e                  state;
  logic [3:0]              wait_cnt;
  logic [IDX_W-1:0]        idx;
  err_e                    err;
  logic                    ro_sel;
  logic [DATA_WIDTH-1:0]   rd_word;
  logic                    commit;
  logic [NUM_REGS-1:0]     reg_we;
  logic [ADDR_WIDTH-1:0]   paddr_unused;

  // Address bits above the index are aliased by design.
  assign paddr_unused = PADDR;
  assign idx          = PADDR[ADDR_LSB +: IDX_W];

  always_comb begin
    rd_word = '0;
    ro_sel  = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (idx == IDX_W'(i)) begin
        rd_word = reg_q[i*DATA_WIDTH +: DATA_WIDTH];
        ro_sel  = RO_MASK[i];
      end
    end
    if ((PADDR & ALIGN_MASK) != '0)      err = ERR_UNALIGNED;
    else if (idx >= IDX_W'(NUM_REGS))    err = ERR_RANGE;
    else if (PWRITE && ro_sel)           err = ERR_RO;
    else                                 err = ERR_NONE;
  end

  // Handshake: a transfer completes on the PCLK edge where PSEL, PENABLE and
  // PREADY are all high; PSLVERR and read data are meaningful only then.
  assign PREADY  = (state == ACCESS) && (wait_cnt == 4'd0) && PSEL;
  assign PSLVERR = PREADY && (err != ERR_NONE);
  assign commit  = PREADY && PWRITE && (err == ERR_NONE);

  always_comb begin
    reg_we = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      reg_we[i] = commit && (idx == IDX_W'(i));
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
    apb_byte_reg #(
      .DATA_WIDTH (DATA_WIDTH),
      .RESET_VAL  (RESET_VAL[g*DATA_WIDTH +: DATA_WIDTH])
    ) u_reg (
      .clk   (PCLK),
      .rst_n (PRESETn),
      .we    (reg_we[g]),
      .strb  (PSTRB),
      .wdata (PWDATA),
      .q     (reg_q[g*DATA_WIDTH +: DATA_WIDTH])
    );
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state    <= IDLE;
      wait_cnt <= 4'd0;
      PRDATA   <= '0;
      wr_pulse <= '0;
    end else begin
      wr_pulse <= reg_we;
      case (state)
        IDLE: begin
          if (PSEL && !PENABLE) state <= SETUP;
        end
        SETUP: begin
          if (!PSEL) begin
            state <= IDLE;
          end else if (PENABLE) begin
            state    <= ACCESS;
            wait_cnt <= 4'(WAIT_STATES);
            if (!PWRITE) PRDATA <= (err == ERR_NONE) ? rd_word : '0;
          end
        end
        ACCESS: begin
          // Losing PSEL before completion aborts the transfer without side effects.
          if (!PSEL)                   state    <= IDLE;
          else if (wait_cnt != 4'd0)   wait_cnt <= wait_cnt - 4'd1;
          else                         state    <= !PENABLE ? SETUP : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
